// File: rtl/axi_pkg.sv
// Shared AXI burst encodings, response codes and FSM state types for the slave memory.
package axi_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10,
        RSVD  = 2'b11
    } burst_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic [0:0] {
        R_IDLE,
        R_DATA
    } r_state_e;

    // True when the byte address falls past the last word of the memory.
    function automatic logic word_oob(input logic [31:0] addr, input int unsigned depth);
        return ({2'b00, addr[31:2]} >= 32'(depth));
    endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational next-beat address generator and burst legality check.
module axi_burst_addr
    import axi_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [2:0]  size,
    input  logic [3:0]  len,
    input  burst_e      burst,
    output logic [31:0] next_addr,
    output logic        burst_err
);

    logic [31:0] step_bytes;
    logic [31:0] incr_addr;
    logic [31:0] wrap_bytes;
    logic [31:0] wrap_mask;
    logic [31:0] wrap_base;
    logic        len_ok;

    always_comb begin
        step_bytes = 32'd1 << size;
        incr_addr  = addr + step_bytes;
        wrap_bytes = (32'(len) + 32'd1) << size;
        wrap_mask  = ~(wrap_bytes - 32'd1);
        wrap_base  = addr & wrap_mask;
        len_ok     = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);

        next_addr = addr;
        case (burst)
            FIXED:   next_addr = addr;
            INCR:    next_addr = incr_addr;
            // Leaving the aligned wrap window means the boundary was reached.
            WRAP:    next_addr = (len_ok && ((incr_addr & wrap_mask) != wrap_base))
                                 ? wrap_base : incr_addr;
            default: next_addr = incr_addr;
        endcase

        burst_err = (size > 3'd2) || (burst == RSVD) || ((burst == WRAP) && !len_ok);
    end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI slave terminating all five channels onto a byte-strobed word memory,
// with independent single-outstanding write and read burst engines.
module axi_slave_mem
    import axi_pkg::*;
#(
    parameter int MEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready,
    input  logic        awlock,
    input  logic        awcache,
    input  logic        awprot,
    input  logic        awqos,
    input  logic        awregion,
    input  logic        awuser,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    input  logic [3:0]  wid,
    input  logic        wuser,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        buser,
    output logic        bvalid,
    input  logic        bready,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready,
    input  logic        arlock,
    input  logic        arcache,
    input  logic        arprot,
    input  logic        arqos,
    input  logic        arregion,
    input  logic        aruser,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [3:0]  rresp,
    output logic        rlast,
    output logic        ruser,
    output logic        rvalid,
    input  logic        rready
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [31:0] mem [MEM_DEPTH];

    logic unused_inputs;
    assign unused_inputs = ^{awlock, awcache, awprot, awqos, awregion, awuser,
                             wid, wuser, arlock, arcache, arprot, arqos, arregion, aruser};

    // ---------------- write engine ----------------
    w_state_e    w_state_reg, w_state_next;
    logic        aw_ready_reg;
    logic [3:0]  w_id_reg;
    logic [31:0] w_addr_reg;
    logic [3:0]  w_len_reg;
    logic [2:0]  w_size_reg;
    burst_e      w_burst_reg;
    logic [3:0]  w_count_reg;
    logic        w_err_reg;
    logic [31:0] w_next_addr;
    logic        w_burst_err;
    logic        aw_hs, w_beat, w_is_last, w_beat_err;
    logic [IDX_W-1:0] w_idx;

    axi_burst_addr u_w_addr (
        .addr      (w_addr_reg),
        .size      (w_size_reg),
        .len       (w_len_reg),
        .burst     (w_burst_reg),
        .next_addr (w_next_addr),
        .burst_err (w_burst_err)
    );

    assign aw_hs      = awvalid && aw_ready_reg && (w_state_reg == W_IDLE);
    assign w_beat     = wvalid && (w_state_reg == W_DATA);
    assign w_is_last  = (w_count_reg == w_len_reg);
    assign w_beat_err = w_burst_err || word_oob(w_addr_reg, MEM_DEPTH) || (wlast != w_is_last);
    assign w_idx      = w_addr_reg[IDX_W+1:2];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state_reg  <= W_IDLE;
            aw_ready_reg <= 1'b0;
        end else begin
            w_state_reg  <= w_state_next;
            aw_ready_reg <= (w_state_next == W_IDLE);
        end
    end

    always_comb begin
        w_state_next = w_state_reg;
        wready       = 1'b0;
        bvalid       = 1'b0;
        bid          = 4'd0;
        bresp        = OKAY;
        buser        = 1'b0;
        case (w_state_reg)
            W_IDLE: if (aw_hs) w_state_next = W_DATA;
            W_DATA: begin
                wready = 1'b1;
                if (wvalid && w_is_last) w_state_next = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                bid    = w_id_reg;
                bresp  = w_err_reg ? SLVERR : OKAY;
                if (bready) w_state_next = W_IDLE;
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_id_reg    <= 4'd0;
            w_addr_reg  <= 32'd0;
            w_len_reg   <= 4'd0;
            w_size_reg  <= 3'd0;
            w_burst_reg <= FIXED;
            w_count_reg <= 4'd0;
            w_err_reg   <= 1'b0;
        end else if (aw_hs) begin
            w_id_reg    <= awid;
            w_addr_reg  <= awaddr;
            w_len_reg   <= awlen;
            w_size_reg  <= awsize;
            w_burst_reg <= burst_e'(awburst);
            w_count_reg <= 4'd0;
            w_err_reg   <= 1'b0;
        end else if (w_beat) begin
            w_addr_reg  <= w_next_addr;
            w_count_reg <= w_count_reg + 4'd1;
            w_err_reg   <= w_err_reg | w_beat_err;
        end
    end

    // Memory contents survive reset; only good beats commit.
    always_ff @(posedge clk) begin
        if (w_beat && !w_beat_err) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[w_idx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // ---------------- read engine ----------------
    r_state_e    r_state_reg, r_state_next;
    logic        ar_ready_reg;
    logic [3:0]  r_id_reg;
    logic [31:0] r_addr_reg;
    logic [3:0]  r_len_reg;
    logic [2:0]  r_size_reg;
    burst_e      r_burst_reg;
    logic [3:0]  r_count_reg;
    logic [31:0] r_next_addr;
    logic        r_burst_err;
    logic        ar_hs, r_beat, r_is_last, r_beat_err;
    logic [IDX_W-1:0] r_idx;

    axi_burst_addr u_r_addr (
        .addr      (r_addr_reg),
        .size      (r_size_reg),
        .len       (r_len_reg),
        .burst     (r_burst_reg),
        .next_addr (r_next_addr),
        .burst_err (r_burst_err)
    );

    assign ar_hs      = arvalid && ar_ready_reg && (r_state_reg == R_IDLE);
    assign r_beat     = rready && (r_state_reg == R_DATA);
    assign r_is_last  = (r_count_reg == r_len_reg);
    assign r_beat_err = r_burst_err || word_oob(r_addr_reg, MEM_DEPTH);
    assign r_idx      = r_addr_reg[IDX_W+1:2];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state_reg  <= R_IDLE;
            ar_ready_reg <= 1'b0;
        end else begin
            r_state_reg  <= r_state_next;
            ar_ready_reg <= (r_state_next == R_IDLE);
        end
    end

    // Read data is an asynchronous array read so a same-cycle write sees old data.
    always_comb begin
        r_state_next = r_state_reg;
        rvalid       = 1'b0;
        rid          = 4'd0;
        rdata        = 32'd0;
        rresp        = 4'd0;
        rlast        = 1'b0;
        ruser        = 1'b0;
        case (r_state_reg)
            R_IDLE: if (ar_hs) r_state_next = R_DATA;
            R_DATA: begin
                rvalid = 1'b1;
                rid    = r_id_reg;
                rdata  = r_beat_err ? 32'd0 : mem[r_idx];
                rresp  = {2'b00, (r_beat_err ? SLVERR : OKAY)};
                rlast  = r_is_last;
                if (rready && r_is_last) r_state_next = R_IDLE;
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_id_reg    <= 4'd0;
            r_addr_reg  <= 32'd0;
            r_len_reg   <= 4'd0;
            r_size_reg  <= 3'd0;
            r_burst_reg <= FIXED;
            r_count_reg <= 4'd0;
        end else if (ar_hs) begin
            r_id_reg    <= arid;
            r_addr_reg  <= araddr;
            r_len_reg   <= arlen;
            r_size_reg  <= arsize;
            r_burst_reg <= burst_e'(arburst);
            r_count_reg <= 4'd0;
        end else if (r_beat) begin
            r_addr_reg  <= r_next_addr;
            r_count_reg <= r_count_reg + 4'd1;
        end
    end

    assign awready = aw_ready_reg;
    assign arready = ar_ready_reg;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed scoreboard bench for axi_slave_mem: expected B/R responses are queued
// as stimulus is issued and compared when the slave presents them.
module tb_axi_slave_mem;
    import axi_pkg::*;

    localparam int TMO = 200;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [3:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic [3:0]  awlen = '0;
    logic [2:0]  awsize = '0;
    logic [1:0]  awburst = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        buser;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [3:0]  arid = '0;
    logic [31:0] araddr = '0;
    logic [3:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic [1:0]  arburst = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [3:0]  rresp;
    logic        rlast;
    logic        ruser;
    logic        rvalid;
    logic        rready = 1'b0;

    always #5 clk = ~clk;

    axi_slave_mem #(.MEM_DEPTH(256)) dut (
        .clk(clk), .rstn(rstn),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .awlock(1'b0), .awcache(1'b0), .awprot(1'b0), .awqos(1'b0), .awregion(1'b0), .awuser(1'b0),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .wid(4'd0), .wuser(1'b0),
        .bid(bid), .bresp(bresp), .buser(buser), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .arlock(1'b0), .arcache(1'b0), .arprot(1'b0), .arqos(1'b0), .arregion(1'b0), .aruser(1'b0),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .ruser(ruser),
        .rvalid(rvalid), .rready(rready)
    );

    typedef struct { logic [3:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct { logic [3:0] id; logic [31:0] data; logic [3:0] resp; logic last; } r_exp_t;

    b_exp_t      b_q[$];
    r_exp_t      r_q[$];
    logic [31:0] model [0:255];
    int          checks = 0;
    int          passes = 0;
    int          fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] out_bits();
        return 32'({awready, wready, bvalid, bid, bresp, buser,
                    arready, rvalid, rid, rresp, rlast, ruser});
    endfunction

    task automatic push_r(input logic [3:0] id, input logic [31:0] d, input logic [3:0] resp, input logic last);
        r_exp_t e;
        e.id = id; e.data = d; e.resp = resp; e.last = last;
        r_q.push_back(e);
    endtask

    task automatic aw_send(input logic [31:0] a, input logic [3:0] l, input logic [2:0] s,
                           input logic [1:0] b, input logic [3:0] id);
        int n = 0;
        awaddr = a; awlen = l; awsize = s; awburst = b; awid = id; awvalid = 1'b1;
        while (!awready && n < TMO) begin step(); n++; end
        if (!awready) chk("aw_timeout", 32'(awready), 32'd1);
        step();
        awvalid = 1'b0;
        chk("awready_drop", 32'(awready), 32'd0);
    endtask

    task automatic w_send(input logic [31:0] d, input logic [3:0] st, input logic last);
        int n = 0;
        wdata = d; wstrb = st; wlast = last; wvalid = 1'b1;
        while (!wready && n < TMO) begin step(); n++; end
        if (!wready) chk("w_timeout", 32'(wready), 32'd1);
        step();
        wvalid = 1'b0;
    endtask

    task automatic b_take(input int stall);
        int n = 0;
        b_exp_t e;
        bready = 1'b0;
        while (!bvalid && n < TMO) begin step(); n++; end
        if (!bvalid) begin chk("b_timeout", 32'(bvalid), 32'd1); return; end
        e = b_q.pop_front();
        for (int k = 0; k < stall; k++) begin
            chk("b_stall_valid", 32'(bvalid), 32'd1);
            chk("b_stall_awready", 32'(awready), 32'd0);
            chk("b_stall_resp", 32'(bresp), 32'(e.resp));
            step();
        end
        bready = 1'b1;
        chk("bid", 32'(bid), 32'(e.id));
        chk("bresp", 32'(bresp), 32'(e.resp));
        chk("buser", 32'(buser), 32'd0);
        step();
        bready = 1'b0;
        chk("awready_back", 32'(awready), 32'd1);
    endtask

    task automatic wr_burst(input logic [31:0] a, input logic [3:0] l, input logic [2:0] s,
                            input logic [1:0] b, input logic [3:0] id, input logic [31:0] base,
                            input logic [3:0] st, input logic [15:0] lastpat,
                            input logic [1:0] eresp, input int bstall);
        b_exp_t e;
        e.id = id; e.resp = eresp;
        b_q.push_back(e);
        aw_send(a, l, s, b, id);
        for (int i = 0; i <= int'(l); i++) w_send(base + 32'(i), st, lastpat[i]);
        b_take(bstall);
    endtask

    task automatic rd_burst(input logic [31:0] a, input logic [3:0] l, input logic [2:0] s,
                            input logic [1:0] b, input logic [3:0] id, input int stall);
        int n;
        r_exp_t e;
        araddr = a; arlen = l; arsize = s; arburst = b; arid = id; arvalid = 1'b1;
        n = 0;
        while (!arready && n < TMO) begin step(); n++; end
        if (!arready) chk("ar_timeout", 32'(arready), 32'd1);
        step();
        arvalid = 1'b0;
        chk("arready_drop", 32'(arready), 32'd0);
        for (int i = 0; i <= int'(l); i++) begin
            rready = (i > 0 || stall == 0);
            n = 0;
            while (!rvalid && n < TMO) begin step(); n++; end
            if (!rvalid) begin chk("r_timeout", 32'(rvalid), 32'd1); rready = 1'b0; return; end
            e = r_q.pop_front();
            if (i == 0) begin
                for (int k = 0; k < stall; k++) begin
                    chk("r_stall_valid", 32'(rvalid), 32'd1);
                    chk("r_stall_data", rdata, e.data);
                    step();
                end
            end
            rready = 1'b1;
            chk("rid", 32'(rid), 32'(e.id));
            chk("rdata", rdata, e.data);
            chk("rresp", 32'(rresp), 32'(e.resp));
            chk("rlast", 32'(rlast), 32'(e.last));
            chk("ruser", 32'(ruser), 32'd0);
            step();
        end
        rready = 1'b0;
        chk("arready_back", 32'(arready), 32'd1);
    endtask

    initial begin
        // Reset: every output low while held, ready channels high after release.
        step(); step();
        chk("rst_outputs", out_bits(), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        #4 rstn = 1'b1;
        step();
        chk("rel_awready", 32'(awready), 32'd1);
        chk("rel_arready", 32'(arready), 32'd1);

        // INCR write then read back.
        wr_burst(32'h10, 4'd3, 3'd2, INCR, 4'd3, 32'hA0, 4'hF, 16'h0008, OKAY, 0);
        for (int i = 0; i < 4; i++) model[4+i] = 32'hA0 + 32'(i);
        for (int i = 0; i < 4; i++) push_r(4'd5, model[4+i], 4'd0, i == 3);
        rd_burst(32'h10, 4'd3, 3'd2, INCR, 4'd5, 0);

        // WRAP: beats land on 0x18, 0x1C, 0x10, 0x14.
        wr_burst(32'h18, 4'd3, 3'd2, WRAP, 4'd1, 32'hB0, 4'hF, 16'h0008, OKAY, 0);
        model[6] = 32'hB0; model[7] = 32'hB1; model[4] = 32'hB2; model[5] = 32'hB3;
        push_r(4'd2, 32'hB0, 4'd0, 1'b0);
        push_r(4'd2, 32'hB1, 4'd0, 1'b0);
        push_r(4'd2, 32'hB2, 4'd0, 1'b0);
        push_r(4'd2, 32'hB3, 4'd0, 1'b1);
        rd_burst(32'h18, 4'd3, 3'd2, WRAP, 4'd2, 0);

        // Byte strobes, then a read held off for three cycles.
        wr_burst(32'h0, 4'd0, 3'd2, INCR, 4'd1, 32'hDEADBEEF, 4'hF, 16'h0001, OKAY, 0);
        wr_burst(32'h0, 4'd0, 3'd2, INCR, 4'd1, 32'h11223344, 4'b0101, 16'h0001, OKAY, 0);
        model[0] = 32'hDE22BE44;
        push_r(4'd8, 32'hDE22BE44, 4'd0, 1'b1);
        rd_burst(32'h0, 4'd0, 3'd2, INCR, 4'd8, 3);

        // Out-of-range write is rejected and must not alias onto word 0.
        wr_burst(32'h400, 4'd0, 3'd2, INCR, 4'd9, 32'h55, 4'hF, 16'h0001, SLVERR, 0);
        push_r(4'd9, model[0], 4'd0, 1'b1);
        rd_burst(32'h0, 4'd0, 3'd2, INCR, 4'd9, 0);
        push_r(4'd9, 32'd0, 4'd2, 1'b1);
        rd_burst(32'h400, 4'd0, 3'd2, INCR, 4'd9, 0);

        // Early wlast on beat 2 poisons the response and drops only that beat.
        wr_burst(32'h40, 4'd3, 3'd2, INCR, 4'd4, 32'hF0, 4'hF, 16'h0008, OKAY, 0);
        for (int i = 0; i < 4; i++) model[16+i] = 32'hF0 + 32'(i);
        wr_burst(32'h40, 4'd3, 3'd2, INCR, 4'd4, 32'hC0, 4'hF, 16'h000A, SLVERR, 0);
        model[16] = 32'hC0; model[18] = 32'hC2; model[19] = 32'hC3;
        for (int i = 0; i < 4; i++) push_r(4'd4, model[16+i], 4'd0, i == 3);
        rd_burst(32'h40, 4'd3, 3'd2, INCR, 4'd4, 0);

        // Oversized beats: every beat errors with zero data.
        push_r(4'd6, 32'd0, 4'd2, 1'b0);
        push_r(4'd6, 32'd0, 4'd2, 1'b1);
        rd_burst(32'h10, 4'd1, 3'd3, INCR, 4'd6, 0);

        // Concurrent write and read on disjoint words.
        for (int i = 0; i < 4; i++) push_r(4'd3, model[4+i], 4'd0, i == 3);
        fork
            wr_burst(32'h80, 4'd1, 3'd2, INCR, 4'd7, 32'hD0, 4'hF, 16'h0002, OKAY, 0);
            rd_burst(32'h10, 4'd3, 3'd2, INCR, 4'd3, 0);
        join
        model[32] = 32'hD0; model[33] = 32'hD1;
        push_r(4'd7, model[32], 4'd0, 1'b0);
        push_r(4'd7, model[33], 4'd0, 1'b1);
        rd_burst(32'h80, 4'd1, 3'd2, INCR, 4'd7, 0);

        // Response held off for five cycles.
        wr_burst(32'h84, 4'd0, 3'd2, INCR, 4'd6, 32'h77, 4'hF, 16'h0001, OKAY, 5);
        model[33] = 32'h77;
        push_r(4'd6, model[33], 4'd0, 1'b1);
        rd_burst(32'h84, 4'd0, 3'd2, INCR, 4'd6, 0);

        // Reset in the middle of a write burst.
        aw_send(32'h20, 4'd3, 3'd2, INCR, 4'd2);
        w_send(32'hE0, 4'hF, 1'b0);
        w_send(32'hE1, 4'hF, 1'b0);
        model[8] = 32'hE0; model[9] = 32'hE1;
        rstn = 1'b0;
        #2;
        chk("midrst_outputs", out_bits(), 32'd0);
        chk("midrst_rdata", rdata, 32'd0);
        step(); step();
        #4 rstn = 1'b1;
        step();
        chk("midrel_awready", 32'(awready), 32'd1);
        chk("midrel_arready", 32'(arready), 32'd1);
        wr_burst(32'h30, 4'd1, 3'd2, INCR, 4'd5, 32'h90, 4'hF, 16'h0002, OKAY, 0);
        model[12] = 32'h90; model[13] = 32'h91;
        push_r(4'd1, model[8], 4'd0, 1'b0);
        push_r(4'd1, model[9], 4'd0, 1'b1);
        rd_burst(32'h20, 4'd1, 3'd2, INCR, 4'd1, 0);
        push_r(4'd1, model[12], 4'd0, 1'b0);
        push_r(4'd1, model[13], 4'd0, 1'b1);
        rd_burst(32'h30, 4'd1, 3'd2, INCR, 4'd1, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
